// File: rtl/wb_burst_master.sv
// Wishbone B4 pipelined burst initiator.
// Takes one read or write burst command at a time, issues strobes with stall
// handling, counts acks, streams read data out, and reports completion or abort.
module wb_burst_master #(
  parameter int AW      = 10,
  parameter int DW      = 8,
  parameter int LW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [LW-1:0] i_cmd_len,
  input  logic [DW-1:0] i_cmd_data,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  output logic          o_done,
  output logic          o_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data
);

  // Beat counters need one extra bit: a burst can be 2^LW beats long.
  localparam int CW = LW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic          cyc_r;
  logic          stb_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] data_r;
  logic [LW-1:0] len_r;
  logic [CW-1:0] issued;
  logic [CW-1:0] acked;
  logic [TW-1:0] tmo;
  logic          rd_valid_r;
  logic [DW-1:0] rd_data_r;
  logic          done_r;
  logic          err_r;
  logic          cmd_ready_r;

  logic          active;
  logic          issue;
  logic          ack_ok;
  logic          last_issue;
  logic          all_acked;
  logic          timeout_hit;
  logic [CW-1:0] beats;
  logic [CW-1:0] issued_n;
  logic [CW-1:0] acked_n;

  // Per-cycle bus events: beat issue, accepted ack, completion and timeout.
  always_comb begin
    active      = (state == S_REQ) || (state == S_WAIT);
    beats       = CW'(len_r) + CW'(1);
    issue       = (state == S_REQ) && stb_r && !i_wb_stall;
    // Only acks for beats already on the bus count; strays are dropped.
    ack_ok      = active && i_wb_ack && !i_wb_err && (acked < issued);
    issued_n    = issued + CW'(issue);
    acked_n     = acked + CW'(ack_ok);
    last_issue  = issue && (issued_n == beats);
    all_acked   = (acked_n == beats);
    timeout_hit = active && !i_wb_ack && !issue && (tmo == TW'(TIMEOUT - 1));
  end

  // Burst sequencer with registered bus and status outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      len_r       <= '0;
      issued      <= '0;
      acked       <= '0;
      tmo         <= '0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            we_r        <= i_cmd_we;
            addr_r      <= i_cmd_addr;
            len_r       <= i_cmd_len;
            data_r      <= i_cmd_data;
            cyc_r       <= 1'b1;
            stb_r       <= 1'b1;
            cmd_ready_r <= 1'b0;
            issued      <= '0;
            acked       <= '0;
            tmo         <= '0;
            state       <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (i_wb_err || timeout_hit) begin
            cyc_r  <= 1'b0;
            stb_r  <= 1'b0;
            done_r <= 1'b1;
            err_r  <= 1'b1;
            state  <= S_DONE;
          end else begin
            issued <= issued_n;
            acked  <= acked_n;
            if (issue || i_wb_ack) tmo <= '0;
            else                   tmo <= tmo + TW'(1);
            if (issue) addr_r <= addr_r + AW'(1);
            if (ack_ok && !we_r) begin
              rd_valid_r <= 1'b1;
              rd_data_r  <= i_wb_data;
            end
            // Completion wins over the REQ->WAIT step so a burst whose acks
            // are already all in goes straight to DONE.
            if (all_acked) begin
              cyc_r  <= 1'b0;
              stb_r  <= 1'b0;
              done_r <= 1'b1;
              state  <= S_DONE;
            end else if (last_issue) begin
              stb_r <= 1'b0;
              state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          cmd_ready_r <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = cmd_ready_r;
  assign o_rd_valid  = rd_valid_r;
  assign o_rd_data   = rd_data_r;
  assign o_done      = done_r;
  assign o_err       = err_r;
  assign o_wb_cyc    = cyc_r;
  assign o_wb_stb    = stb_r;
  assign o_wb_we     = we_r;
  assign o_wb_addr   = addr_r;
  assign o_wb_data   = data_r;
  assign o_wb_sel    = '1;

endmodule

// File: tb/tb_wb_burst_master.sv
// Testbench for wb_burst_master: a behavioural pipelined slave plus bus
// monitor, a table of burst scenarios, and a hand-written mid-burst reset.
module tb_wb_burst_master;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic       i_cmd_we = 1'b0;
  logic [9:0] i_cmd_addr = '0;
  logic [7:0] i_cmd_len = '0;
  logic [7:0] i_cmd_data = '0;
  logic       o_rd_valid;
  logic [7:0] o_rd_data;
  logic       o_done;
  logic       o_err;
  logic       o_wb_cyc;
  logic       o_wb_stb;
  logic       o_wb_we;
  logic [9:0] o_wb_addr;
  logic [7:0] o_wb_data;
  logic [0:0] o_wb_sel;
  logic       i_wb_stall = 1'b0;
  logic       i_wb_ack = 1'b0;
  logic       i_wb_err = 1'b0;
  logic [7:0] i_wb_data = '0;

  wb_burst_master #(.AW(10), .DW(8), .LW(8), .TIMEOUT(64)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_cmd_data(i_cmd_data),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_done(o_done), .o_err(o_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic            we;
    logic [9:0]      addr;
    logic [7:0]      len;
    logic [7:0]      data;
    int              stall;
    int              err_at;
    logic            no_ack;
    logic [3:0][7:0] rdat;
    int              exp_issues;
    int              exp_rd;
    logic            exp_err;
    int              exp_gap;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Slave configuration, written only by the test sequence.
  int              cmd_seq = 0;
  int              cfg_stall = 0;
  int              cfg_err_at = -1;
  logic            cfg_no_ack = 1'b0;
  logic [3:0][7:0] cfg_rdat = '0;

  // Monitor state, written only by the monitor/slave process.
  int         seen_seq = 0;
  int         cycle = 0;
  int         stall_left = 0;
  int         stall_cnt = 0;
  int         stall_bad = 0;
  logic [9:0] stall_addr = '0;
  int         ack_idx = 0;
  logic       pending = 1'b0;
  int         last_issue = 0;
  int         done_cnt = 0;
  logic       done_err = 1'b0;
  int         done_cycle = 0;
  logic [9:0] iss_addr[$];
  logic       iss_we[$];
  logic [7:0] iss_dat[$];
  logic [7:0] rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave + monitor: at each falling edge record DUT outputs, then drive the
  // slave inputs that the next rising edge will sample. A beat accepted on
  // one edge is acked on the following edge.
  initial begin
    forever begin
      @(negedge i_clk);
      cycle++;
      i_wb_ack  = 1'b0;
      i_wb_err  = 1'b0;
      i_wb_data = '0;
      if (!i_reset_n) begin
        pending    = 1'b0;
        stall_left = 0;
        i_wb_stall = 1'b0;
      end else begin
        if (cmd_seq != seen_seq) begin
          seen_seq   = cmd_seq;
          stall_left = cfg_stall;
          stall_cnt  = 0;
          stall_bad  = 0;
          ack_idx    = 0;
          done_cnt   = 0;
          iss_addr.delete();
          iss_we.delete();
          iss_dat.delete();
          rd_q.delete();
        end
        if (o_rd_valid) rd_q.push_back(o_rd_data);
        if (o_done) begin
          done_cnt++;
          done_err   = o_err;
          done_cycle = cycle;
        end
        if (pending && !cfg_no_ack) begin
          if (ack_idx == cfg_err_at) i_wb_err = 1'b1;
          else begin
            i_wb_ack  = 1'b1;
            i_wb_data = cfg_rdat[ack_idx & 3];
          end
          ack_idx++;
        end
        i_wb_stall = (stall_left > 0) && o_wb_cyc && o_wb_stb;
        if (i_wb_stall) begin
          stall_left--;
          stall_cnt++;
          if (stall_cnt > 1 && o_wb_addr != stall_addr) stall_bad++;
          stall_addr = o_wb_addr;
        end
        pending = o_wb_cyc && o_wb_stb && !i_wb_stall;
        if (pending) begin
          iss_addr.push_back(o_wb_addr);
          iss_we.push_back(o_wb_we);
          iss_dat.push_back(o_wb_data);
          last_issue = cycle + 1;
        end
      end
    end
  end

  task automatic send_cmd(input vec_t v);
    @(negedge i_clk); #1;
    cfg_stall   = v.stall;
    cfg_err_at  = v.err_at;
    cfg_no_ack  = v.no_ack;
    cfg_rdat    = v.rdat;
    cmd_seq++;
    i_cmd_valid = 1'b1;
    i_cmd_we    = v.we;
    i_cmd_addr  = v.addr;
    i_cmd_len   = v.len;
    i_cmd_data  = v.data;
    @(negedge i_clk); #1;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = ~v.addr;
    i_cmd_len   = ~v.len;
    i_cmd_data  = ~v.data;
    i_cmd_we    = ~v.we;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int gap;
    send_cmd(v);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      @(negedge i_clk); #1;
    end
    chk($sformatf("v%0d done_seen", n), done_cnt, 1);
    gap = done_cycle - last_issue;
    @(negedge i_clk); #1;
    chk($sformatf("v%0d cyc_after_done", n), o_wb_cyc, 0);
    chk($sformatf("v%0d stb_after_done", n), o_wb_stb, 0);
    chk($sformatf("v%0d cmd_ready_after_done", n), o_cmd_ready, 1);
    repeat (3) @(negedge i_clk);
    #1;
    chk($sformatf("v%0d issues", n), iss_addr.size(), v.exp_issues);
    for (int i = 0; i < v.exp_issues && i < iss_addr.size(); i++) begin
      chk($sformatf("v%0d addr[%0d]", n, i), iss_addr[i], (v.addr + 10'(i)) & 10'h3FF);
      chk($sformatf("v%0d we[%0d]", n, i), iss_we[i], v.we);
      if (v.we) chk($sformatf("v%0d wdata[%0d]", n, i), iss_dat[i], v.data);
    end
    chk($sformatf("v%0d rd_count", n), rd_q.size(), v.exp_rd);
    for (int i = 0; i < v.exp_rd && i < rd_q.size(); i++)
      chk($sformatf("v%0d rd_data[%0d]", n, i), rd_q[i], v.rdat[i[1:0]]);
    chk($sformatf("v%0d done_count", n), done_cnt, 1);
    chk($sformatf("v%0d err", n), done_err, v.exp_err);
    chk($sformatf("v%0d done_gap", n), gap, v.exp_gap);
    chk($sformatf("v%0d stall_cycles", n), stall_cnt, v.stall);
    chk($sformatf("v%0d stall_hold", n), stall_bad, 0);
  endtask

  vec_t vecs[6];
  vec_t post;

  initial begin
    vecs[0] = '{we: 1'b1, addr: 10'h010, len: 8'd3, data: 8'hA5, stall: 0, err_at: -1,
                no_ack: 1'b0, rdat: 32'h0, exp_issues: 4, exp_rd: 0, exp_err: 1'b0, exp_gap: 1};
    vecs[1] = '{we: 1'b0, addr: 10'h3FE, len: 8'd3, data: 8'h00, stall: 0, err_at: -1,
                no_ack: 1'b0, rdat: 32'h44332211, exp_issues: 4, exp_rd: 4, exp_err: 1'b0, exp_gap: 1};
    vecs[2] = '{we: 1'b0, addr: 10'h055, len: 8'd0, data: 8'h00, stall: 5, err_at: -1,
                no_ack: 1'b0, rdat: 32'h0000005C, exp_issues: 1, exp_rd: 1, exp_err: 1'b0, exp_gap: 1};
    // Third ack comes back as an error; the beat offered on that same edge is
    // the last one seen on the bus.
    vecs[3] = '{we: 1'b1, addr: 10'h100, len: 8'd7, data: 8'h3C, stall: 0, err_at: 2,
                no_ack: 1'b0, rdat: 32'h0, exp_issues: 4, exp_rd: 0, exp_err: 1'b1, exp_gap: 0};
    vecs[4] = '{we: 1'b0, addr: 10'h200, len: 8'd1, data: 8'h00, stall: 0, err_at: -1,
                no_ack: 1'b1, rdat: 32'h0, exp_issues: 2, exp_rd: 0, exp_err: 1'b1, exp_gap: 64};
    vecs[5] = '{we: 1'b1, addr: 10'h3FF, len: 8'd0, data: 8'h96, stall: 0, err_at: -1,
                no_ack: 1'b0, rdat: 32'h0, exp_issues: 1, exp_rd: 0, exp_err: 1'b0, exp_gap: 1};
    post    = '{we: 1'b0, addr: 10'h007, len: 8'd0, data: 8'h00, stall: 0, err_at: -1,
                no_ack: 1'b0, rdat: 32'h000000E1, exp_issues: 1, exp_rd: 1, exp_err: 1'b0, exp_gap: 1};

    repeat (3) @(negedge i_clk);
    #1;
    chk("rst cmd_ready", o_cmd_ready, 1);
    chk("rst cyc", o_wb_cyc, 0);
    chk("rst stb", o_wb_stb, 0);
    chk("rst we", o_wb_we, 0);
    chk("rst addr", o_wb_addr, 0);
    chk("rst wdata", o_wb_data, 0);
    chk("rst rd_valid", o_rd_valid, 0);
    chk("rst rd_data", o_rd_data, 0);
    chk("rst done", o_done, 0);
    chk("rst err", o_err, 0);
    chk("rst sel", o_wb_sel, 1);
    i_reset_n = 1'b1;

    for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

    // Mid-burst reset: drop reset while read data is streaming.
    begin
      vec_t r;
      logic seen;
      r = '{we: 1'b0, addr: 10'h020, len: 8'd3, data: 8'h00, stall: 0, err_at: -1,
            no_ack: 1'b0, rdat: 32'h0A0B0C0D, exp_issues: 4, exp_rd: 4, exp_err: 1'b0, exp_gap: 1};
      send_cmd(r);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge i_clk); #1;
        seen = o_rd_valid;
      end
      chk("mid rd_valid_seen", seen, 1);
      chk("mid cyc_before", o_wb_cyc, 1);
      i_reset_n = 1'b0;
      #1;
      chk("mid cyc", o_wb_cyc, 0);
      chk("mid stb", o_wb_stb, 0);
      chk("mid rd_valid", o_rd_valid, 0);
      chk("mid done", o_done, 0);
      chk("mid cmd_ready", o_cmd_ready, 1);
      repeat (2) @(negedge i_clk);
      #1;
      i_reset_n = 1'b1;
      repeat (3) @(negedge i_clk);
      #1;
      chk("mid no_done", done_cnt, 0);
      chk("mid cmd_ready_after", o_cmd_ready, 1);
      chk("mid cyc_after", o_wb_cyc, 0);
    end

    run_vec(6, post);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
